rv_dmem_arb: RTL and testbench
==============================

RV_DMEM_ARB -- requirements
Module: rv_dmem_arb

Interface
REQ-001 SHALL take parameter EXT_MAX_WAIT, default 4, range 1..15: maximum consecutive cycles an ext request is denied before forced grant.
REQ-002 SHALL take XLEN from rv_pkg, fixed 32.
REQ-003 i_arb_clk  in  1  sole clock; all state on rising edge.
REQ-004 i_arb_rstn  in  1  reset, asynchronous, active-low.
REQ-005 i_arb_core_req / i_arb_core_wen  in  1/1  MEM-stage access request; write when wen=1, else read.
REQ-006 i_arb_core_addr / i_arb_core_wdata  in  XLEN/XLEN  core byte address; lane-aligned write data.
REQ-007 i_arb_core_wstrb  in  XLEN/8  core byte enables.
REQ-008 o_arb_core_gnt / o_arb_core_stall  out  1/1  core access accepted this cycle; stall = core_req & ~core_gnt.
REQ-009 o_arb_core_rvalid / o_arb_core_rdata  out  1/XLEN  core read data valid, one cycle after grant.
REQ-010 i_arb_ext_req, i_arb_ext_wen, i_arb_ext_addr, i_arb_ext_wdata, i_arb_ext_wstrb  in  1,1,XLEN,XLEN,XLEN/8  external (debug/loader) port, same meaning as core.
REQ-011 o_arb_ext_gnt, o_arb_ext_rvalid, o_arb_ext_rdata  out  1,1,XLEN  external grant and response.
REQ-012 o_arb_dmem_en, o_arb_dmem_wen  out  1/1  memory access strobe; write qualifier.
REQ-013 o_arb_dmem_addr, o_arb_dmem_wdata, o_arb_dmem_wstrb  out  XLEN,XLEN,XLEN/8  muxed request to memory.
REQ-014 i_arb_dmem_rdata  in  XLEN  synchronous-read data, valid the cycle after en=1 & wen=0.

Function
REQ-015 Grant SHALL be combinational from current requests and registered state; at most one gnt high per cycle.
REQ-016 Priority: core wins when both request, unless wait counter == EXT_MAX_WAIT, then ext wins.
REQ-017 Wait counter (4 bit): +1 each cycle ext_req=1 and ext_gnt=0; cleared to 0 on ext_gnt or ext_req=0; saturates at EXT_MAX_WAIT.
REQ-018 Memory outputs SHALL carry the granted port's addr/wdata/wstrb/wen; en = core_gnt | ext_gnt; with no grant en=0, wen=0, wstrb=0.
REQ-019 Owner FSM, states OWN_NONE, OWN_CORE_RD, OWN_EXT_RD: next state = OWN_CORE_RD on core read grant, OWN_EXT_RD on ext read grant, OWN_NONE otherwise (incl. writes).
REQ-020 rvalid SHALL assert for exactly one cycle in the matching OWN_*_RD state; rdata = i_arb_dmem_rdata for owner, 0 for non-owner.
REQ-021 Back-to-back grants SHALL be allowed every cycle (throughput 1/cycle); owner updates each cycle without bubble.
REQ-022 Write grants SHALL produce no rvalid.
REQ-023 A request deasserted before grant SHALL be dropped with no side effects.
REQ-024 Address is passed unmodified; alignment and strobe generation are the requester's responsibility.

Reset
REQ-025 While i_arb_rstn=0: owner=OWN_NONE, wait counter=0, all gnt/rvalid/en/wen=0, rdata=0, wstrb=0; asserted asynchronously.
REQ-026 Reset mid-read SHALL suppress the pending rvalid; first cycle after release grants per REQ-016 with counter 0.

Structure
REQ-027 rv_pkg SHALL hold typedef enum dmem_owner_e {OWN_NONE, OWN_CORE_RD, OWN_EXT_RD}; XLEN stays there.
REQ-028 Single flat module; no sub-module.

Verification
REQ-029 Core read only, addr 0x100, mem returns 0xDEADBEEF -> core_gnt same cycle, core_rvalid next cycle with 0xDEADBEEF, ext_rvalid=0.
REQ-030 Core and ext request continuously (EXT_MAX_WAIT=4) -> core granted 4 cycles, ext granted 5th, core_stall=1 that cycle, pattern repeats.
REQ-031 Ext write 0x12345678 wstrb 4'b0011 with core idle -> dmem en=1, wen=1, wstrb=0011 same cycle; no rvalid next cycle.
REQ-032 Core read then ext read consecutive cycles -> core_rvalid cycle N+1, ext_rvalid cycle N+2, each with its own data.
REQ-033 Assert rstn low the cycle after a core read grant -> core_rvalid stays 0, counter 0, all outputs 0.
REQ-034 Ext req waits 2 cycles then drops, re-requests with core busy -> counter restarts at 0; ext grant only after 4 further denials.

Source files
------------

// File: rtl/rv_pkg.sv
// Shared RV data-memory definitions: datapath width and the read-owner
// encoding used by the data-memory arbiter.
package rv_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        OWN_NONE    = 2'd0,
        OWN_CORE_RD = 2'd1,
        OWN_EXT_RD  = 2'd2
    } dmem_owner_e;

endpackage

// File: rtl/rv_dmem_arb.sv
// Two-port data-memory arbiter: core has priority, the external port is
// force-granted after EXT_MAX_WAIT consecutive denials.
//
// state        | meaning
// OWN_NONE     | no read response due this cycle
// OWN_CORE_RD  | memory data this cycle belongs to the core
// OWN_EXT_RD   | memory data this cycle belongs to the external port
module rv_dmem_arb
    import rv_pkg::*;
#(
    parameter int EXT_MAX_WAIT = 4
) (
    input  logic              i_arb_clk,
    input  logic              i_arb_rstn,

    input  logic              i_arb_core_req,
    input  logic              i_arb_core_wen,
    input  logic [XLEN-1:0]   i_arb_core_addr,
    input  logic [XLEN-1:0]   i_arb_core_wdata,
    input  logic [XLEN/8-1:0] i_arb_core_wstrb,
    output logic              o_arb_core_gnt,
    output logic              o_arb_core_stall,
    output logic              o_arb_core_rvalid,
    output logic [XLEN-1:0]   o_arb_core_rdata,

    input  logic              i_arb_ext_req,
    input  logic              i_arb_ext_wen,
    input  logic [XLEN-1:0]   i_arb_ext_addr,
    input  logic [XLEN-1:0]   i_arb_ext_wdata,
    input  logic [XLEN/8-1:0] i_arb_ext_wstrb,
    output logic              o_arb_ext_gnt,
    output logic              o_arb_ext_rvalid,
    output logic [XLEN-1:0]   o_arb_ext_rdata,

    output logic              o_arb_dmem_en,
    output logic              o_arb_dmem_wen,
    output logic [XLEN-1:0]   o_arb_dmem_addr,
    output logic [XLEN-1:0]   o_arb_dmem_wdata,
    output logic [XLEN/8-1:0] o_arb_dmem_wstrb,
    input  logic [XLEN-1:0]   i_arb_dmem_rdata
);

    localparam logic [3:0] MAX_WAIT = 4'(EXT_MAX_WAIT);

    dmem_owner_e owner;
    logic [3:0]  wait_cnt;
    logic        ext_force;

    // Grants are gated by reset so nothing reaches memory while it is held.
    assign ext_force        = i_arb_ext_req & (wait_cnt == MAX_WAIT);
    assign o_arb_core_gnt   = i_arb_rstn & i_arb_core_req & ~ext_force;
    assign o_arb_ext_gnt    = i_arb_rstn & i_arb_ext_req & (~i_arb_core_req | ext_force);
    assign o_arb_core_stall = i_arb_rstn & i_arb_core_req & ~o_arb_core_gnt;

    always_comb begin
        o_arb_dmem_en    = 1'b0;
        o_arb_dmem_wen   = 1'b0;
        o_arb_dmem_addr  = '0;
        o_arb_dmem_wdata = '0;
        o_arb_dmem_wstrb = '0;
        if (o_arb_core_gnt) begin
            o_arb_dmem_en    = 1'b1;
            o_arb_dmem_wen   = i_arb_core_wen;
            o_arb_dmem_addr  = i_arb_core_addr;
            o_arb_dmem_wdata = i_arb_core_wdata;
            o_arb_dmem_wstrb = i_arb_core_wstrb;
        end else if (o_arb_ext_gnt) begin
            o_arb_dmem_en    = 1'b1;
            o_arb_dmem_wen   = i_arb_ext_wen;
            o_arb_dmem_addr  = i_arb_ext_addr;
            o_arb_dmem_wdata = i_arb_ext_wdata;
            o_arb_dmem_wstrb = i_arb_ext_wstrb;
        end
    end

    always_ff @(posedge i_arb_clk or negedge i_arb_rstn) begin
        if (!i_arb_rstn) begin
            owner    <= OWN_NONE;
            wait_cnt <= '0;
        end else begin
            if (o_arb_core_gnt && !i_arb_core_wen) begin
                owner <= OWN_CORE_RD;
            end else if (o_arb_ext_gnt && !i_arb_ext_wen) begin
                owner <= OWN_EXT_RD;
            end else begin
                owner <= OWN_NONE;
            end

            // Counts consecutive denials only; a dropped request starts over.
            if (i_arb_ext_req && !o_arb_ext_gnt) begin
                if (wait_cnt != MAX_WAIT) begin
                    wait_cnt <= wait_cnt + 4'd1;
                end
            end else begin
                wait_cnt <= '0;
            end
        end
    end

    assign o_arb_core_rvalid = (owner == OWN_CORE_RD);
    assign o_arb_ext_rvalid  = (owner == OWN_EXT_RD);
    assign o_arb_core_rdata  = o_arb_core_rvalid ? i_arb_dmem_rdata : '0;
    assign o_arb_ext_rdata   = o_arb_ext_rvalid  ? i_arb_dmem_rdata : '0;

endmodule

// File: tb/tb_rv_dmem_arb.sv
// Scoreboard bench for rv_dmem_arb: stimulus pushes expected grant/read
// events tagged with their cycle; a negedge monitor pops and compares.
module tb_rv_dmem_arb;

    logic        clk;
    logic        rstn;
    logic        core_req, core_wen, ext_req, ext_wen;
    logic [31:0] core_addr, core_wdata, ext_addr, ext_wdata;
    logic [3:0]  core_wstrb, ext_wstrb;
    logic        core_gnt, core_stall, core_rvalid, ext_gnt, ext_rvalid;
    logic [31:0] core_rdata, ext_rdata;
    logic        dmem_en, dmem_wen;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_wstrb;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        int          cyc;
        logic [1:0]  gnt;
        logic        stall;
        logic        wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } gnt_exp_t;

    typedef struct {
        int          cyc;
        logic [1:0]  rv;
        logic [31:0] core_data;
        logic [31:0] ext_data;
    } rd_exp_t;

    gnt_exp_t gnt_q[$];
    rd_exp_t  rd_q[$];

    rv_dmem_arb #(.EXT_MAX_WAIT(4)) dut (
        .i_arb_clk         (clk),
        .i_arb_rstn        (rstn),
        .i_arb_core_req    (core_req),
        .i_arb_core_wen    (core_wen),
        .i_arb_core_addr   (core_addr),
        .i_arb_core_wdata  (core_wdata),
        .i_arb_core_wstrb  (core_wstrb),
        .o_arb_core_gnt    (core_gnt),
        .o_arb_core_stall  (core_stall),
        .o_arb_core_rvalid (core_rvalid),
        .o_arb_core_rdata  (core_rdata),
        .i_arb_ext_req     (ext_req),
        .i_arb_ext_wen     (ext_wen),
        .i_arb_ext_addr    (ext_addr),
        .i_arb_ext_wdata   (ext_wdata),
        .i_arb_ext_wstrb   (ext_wstrb),
        .o_arb_ext_gnt     (ext_gnt),
        .o_arb_ext_rvalid  (ext_rvalid),
        .o_arb_ext_rdata   (ext_rdata),
        .o_arb_dmem_en     (dmem_en),
        .o_arb_dmem_wen    (dmem_wen),
        .o_arb_dmem_addr   (dmem_addr),
        .o_arb_dmem_wdata  (dmem_wdata),
        .o_arb_dmem_wstrb  (dmem_wstrb),
        .i_arb_dmem_rdata  (dmem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous-read memory with fixed contents.
    always @(posedge clk) begin
        if (dmem_en && !dmem_wen) begin
            case (dmem_addr)
                32'h100: dmem_rdata <= 32'hDEADBEEF;
                32'h200: dmem_rdata <= 32'hCAFEF00D;
                32'h300: dmem_rdata <= 32'h0BADC0DE;
                default: dmem_rdata <= 32'hBAD0BAD0;
            endcase
        end
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_gnt(input bit core, input logic stall, input logic wen,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] wstrb);
        gnt_exp_t e;
        e.cyc = cyc;
        e.gnt = core ? 2'b10 : 2'b01;
        e.stall = stall;
        e.wen = wen;
        e.addr = addr;
        e.wdata = wdata;
        e.wstrb = wstrb;
        gnt_q.push_back(e);
    endtask

    task automatic push_rd(input bit core, input logic [31:0] data);
        rd_exp_t r;
        r.cyc = cyc + 1;
        r.rv = core ? 2'b10 : 2'b01;
        r.core_data = core ? data : 32'h0;
        r.ext_data = core ? 32'h0 : data;
        rd_q.push_back(r);
    endtask

    task automatic drive(input logic c_req, input logic c_wen, input logic [31:0] c_addr,
                         input logic e_req, input logic e_wen, input logic [31:0] e_addr,
                         input logic [31:0] e_wdata, input logic [3:0] e_wstrb);
        core_req = c_req;
        core_wen = c_wen;
        core_addr = c_addr;
        core_wdata = 32'h11111111;
        core_wstrb = 4'hF;
        ext_req = e_req;
        ext_wen = e_wen;
        ext_addr = e_addr;
        ext_wdata = e_wdata;
        ext_wstrb = e_wstrb;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h22222222, 4'h0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outs();
        chk("rst_ctrl", 128'({core_gnt, core_stall, core_rvalid, ext_gnt, ext_rvalid,
                             dmem_en, dmem_wen, dmem_wstrb}), 128'(0));
        chk("rst_rdata", 128'({core_rdata, ext_rdata}), 128'(0));
    endtask

    // Monitor: compares whatever the DUT presents against the queued events.
    always @(negedge clk) begin
        if (rstn) begin
            if (core_gnt || ext_gnt) begin
                if (gnt_q.size() == 0) begin
                    chk("unexpected_gnt", 128'({core_gnt, ext_gnt}), 128'(0));
                end else begin
                    gnt_exp_t e;
                    e = gnt_q.pop_front();
                    chk("gnt_cycle", 128'(cyc), 128'(e.cyc));
                    chk("gnt_who_stall", 128'({core_gnt, ext_gnt, core_stall}),
                        128'({e.gnt, e.stall}));
                    chk("mem_bus", 128'({dmem_en, dmem_wen, dmem_addr, dmem_wdata, dmem_wstrb}),
                        128'({1'b1, e.wen, e.addr, e.wdata, e.wstrb}));
                end
            end else begin
                chk("idle_bus", 128'({core_stall, dmem_en, dmem_wen, dmem_wstrb}), 128'(0));
            end
            if (core_rvalid || ext_rvalid) begin
                if (rd_q.size() == 0) begin
                    chk("unexpected_rvalid", 128'({core_rvalid, ext_rvalid}), 128'(0));
                end else begin
                    rd_exp_t r;
                    r = rd_q.pop_front();
                    chk("rd_cycle", 128'(cyc), 128'(r.cyc));
                    chk("rd_who", 128'({core_rvalid, ext_rvalid}), 128'(r.rv));
                    chk("rd_data", 128'({core_rdata, ext_rdata}),
                        128'({r.core_data, r.ext_data}));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        logic [9:0] ext_pat;
        logic [7:0] ext_req_pat;
        logic [4:0] ext_pat5;

        rstn = 1'b0;
        dmem_rdata = 32'h0;
        drive(1'b1, 1'b0, 32'h100, 1'b1, 1'b0, 32'h300, 32'h22222222, 4'h0);
        @(negedge clk);
        chk_reset_outs();
        @(negedge clk);
        chk_reset_outs();
        tick();
        rstn = 1'b1;
        idle();
        tick();

        // Core read, memory answers the following cycle.
        drive(1'b1, 1'b0, 32'h100, 1'b0, 1'b0, 32'h0, 32'h22222222, 4'h0);
        push_gnt(1'b1, 1'b0, 1'b0, 32'h100, 32'h11111111, 4'hF);
        push_rd(1'b1, 32'hDEADBEEF);
        tick();
        idle();
        tick();
        tick();

        // External partial write with core idle: no response afterwards.
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h40, 32'h12345678, 4'b0011);
        push_gnt(1'b0, 1'b0, 1'b1, 32'h40, 32'h12345678, 4'b0011);
        tick();
        idle();
        tick();
        tick();

        // Core read then ext read on consecutive cycles.
        drive(1'b1, 1'b0, 32'h200, 1'b0, 1'b0, 32'h0, 32'h22222222, 4'h0);
        push_gnt(1'b1, 1'b0, 1'b0, 32'h200, 32'h11111111, 4'hF);
        push_rd(1'b1, 32'hCAFEF00D);
        tick();
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h300, 32'h22222222, 4'h5);
        push_gnt(1'b0, 1'b0, 1'b0, 32'h300, 32'h22222222, 4'h5);
        push_rd(1'b0, 32'h0BADC0DE);
        tick();
        idle();
        tick();
        tick();

        // Both requesting continuously: ext forced through every 5th cycle.
        ext_pat = 10'b10_0001_0000;
        for (int k = 0; k < 10; k++) begin
            drive(1'b1, 1'b0, 32'h100, 1'b1, 1'b0, 32'h300, 32'h22222222, 4'h3);
            if (ext_pat[k]) begin
                push_gnt(1'b0, 1'b1, 1'b0, 32'h300, 32'h22222222, 4'h3);
                push_rd(1'b0, 32'h0BADC0DE);
            end else begin
                push_gnt(1'b1, 1'b0, 1'b0, 32'h100, 32'h11111111, 4'hF);
                push_rd(1'b1, 32'hDEADBEEF);
            end
            tick();
        end
        idle();
        tick();
        tick();

        // Ext waits 2 cycles, drops, re-requests: grant only after 4 new denials.
        ext_req_pat = 8'b1111_1011;
        for (int k = 0; k < 8; k++) begin
            drive(1'b1, 1'b0, 32'h100, ext_req_pat[k], 1'b1, 32'h44, 32'hA5A5A5A5, 4'hF);
            if (k == 7) begin
                push_gnt(1'b0, 1'b1, 1'b1, 32'h44, 32'hA5A5A5A5, 4'hF);
            end else begin
                push_gnt(1'b1, 1'b0, 1'b0, 32'h100, 32'h11111111, 4'hF);
                push_rd(1'b1, 32'hDEADBEEF);
            end
            tick();
        end
        idle();
        tick();
        tick();

        // Build up the wait counter, then reset right after a core read grant.
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 1'b0, 32'h100, 1'b1, 1'b0, 32'h300, 32'h22222222, 4'h0);
            push_gnt(1'b1, 1'b0, 1'b0, 32'h100, 32'h11111111, 4'hF);
            if (k < 2) push_rd(1'b1, 32'hDEADBEEF);
            tick();
        end
        rstn = 1'b0;
        @(negedge clk);
        chk_reset_outs();
        @(negedge clk);
        chk_reset_outs();
        tick();
        rstn = 1'b1;

        // Counter restarted at 0: four core grants before ext is forced.
        ext_pat5 = 5'b1_0000;
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 1'b0, 32'h200, 1'b1, 1'b0, 32'h300, 32'h22222222, 4'h0);
            if (ext_pat5[k]) begin
                push_gnt(1'b0, 1'b1, 1'b0, 32'h300, 32'h22222222, 4'h0);
                push_rd(1'b0, 32'h0BADC0DE);
            end else begin
                push_gnt(1'b1, 1'b0, 1'b0, 32'h200, 32'h11111111, 4'hF);
                push_rd(1'b1, 32'hCAFEF00D);
            end
            tick();
        end
        idle();
        tick();
        tick();
        tick();

        chk("gnt_q_drained", 128'(gnt_q.size()), 128'(0));
        chk("rd_q_drained", 128'(rd_q.size()), 128'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
